// File: rtl/hk628_voice_scheduler.sv
// HK628 voice scheduler: debounces eight sound buttons, queues note requests and
// dispatches them onto a small pool of timed tone voices. Optional macro: HK628_VOICE_STEAL_EN.
module hk628_voice_scheduler #(
    parameter int NUM_VOICES   = 2,
    parameter int DEBOUNCE_CYC = 250000,
    parameter int NOTE_CYC     = 12500000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                         CLK_50M,
    input  logic                         RESET,
    input  logic [7:0]                   btn,
    input  logic                         low_batt,
    output logic [NUM_VOICES-1:0]        voice_en,
    output logic [3*NUM_VOICES-1:0]      voice_tone,
    output logic [NUM_VOICES-1:0]        voice_start,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overrun
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int CNT_W = $clog2(2 * NOTE_CYC + 1);
    localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    localparam logic [CNT_W-1:0] LOAD_NORM = CNT_W'(NOTE_CYC);
    localparam logic [CNT_W-1:0] LOAD_LOW  = CNT_W'(2 * NOTE_CYC);
    localparam logic [DB_W-1:0]  DB_RELOAD = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [LW-1:0]    FIFO_FULL = LW'(FIFO_DEPTH);

    logic [7:0]      sync1;
    logic [7:0]      sync2;
    logic [7:0]      deb;
    logic [7:0]      deb_q;
    logic [DB_W-1:0] db_cnt [8];

    logic [7:0]      rise;
    logic [7:0]      pend;
    logic [7:0]      pend_clr;
    logic            enq;
    logic [2:0]      enq_code;

    logic [2:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            fifo_full;
    logic            fifo_empty;
    logic [2:0]      head;

    logic [CNT_W-1:0]      cnt [NUM_VOICES];
    logic [NUM_VOICES-1:0] elig;
    logic [NUM_VOICES-1:0] hit;
    logic [NUM_VOICES-1:0] free_v;
    logic [NUM_VOICES-1:0] disp;
    logic                  pop;

    // Debounce: down-counter reloads while the synchronized level agrees with
    // the accepted level; the accepted level flips on terminal count.
    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 8; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 8; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= DB_RELOAD;
                end else if (db_cnt[i] == '0) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= DB_RELOAD;
                end else begin
                    db_cnt[i] <= db_cnt[i] - DB_W'(1);
                end
            end
        end
    end

    assign rise = deb & ~deb_q;

    always_comb begin
        enq      = 1'b0;
        enq_code = '0;
        pend_clr = '0;
        if (!fifo_full) begin
            for (int i = 0; i < 8; i++) begin
                if (pend[i] && !enq) begin
                    enq         = 1'b1;
                    enq_code    = 3'(i);
                    pend_clr[i] = 1'b1;
                end
            end
        end
    end

    // An edge landing on a still-set pending bit is lost, even if that bit
    // is being enqueued in the same cycle.
    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            pend    <= '0;
            overrun <= 1'b0;
        end else begin
            pend <= (pend & ~pend_clr) | (rise & ~pend);
            if (|(rise & pend)) begin
                overrun <= 1'b1;
            end
        end
    end

    assign fifo_full  = (fifo_level == FIFO_FULL);
    assign fifo_empty = (fifo_level == '0);
    assign head       = fifo_mem[rd_ptr];

    always_ff @(posedge CLK_50M) begin
        if (enq) begin
            fifo_mem[wr_ptr] <= enq_code;
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({enq, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_comb begin
        elig   = '0;
        hit    = '0;
        free_v = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            elig[v]   = !low_batt || (v == 0);
            hit[v]    = elig[v] && voice_en[v] && (voice_tone[3*v +: 3] == head);
            free_v[v] = elig[v] && !voice_en[v];
        end
    end

`ifdef HK628_VOICE_STEAL_EN
    logic [NUM_VOICES-1:0] steal_oh;
    logic [CNT_W-1:0]      best_cnt;
    logic                  best_found;

    // Strict less-than keeps ties on the lowest index.
    always_comb begin
        steal_oh   = '0;
        best_cnt   = '0;
        best_found = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (elig[v] && (!best_found || cnt[v] < best_cnt)) begin
                steal_oh    = '0;
                steal_oh[v] = 1'b1;
                best_cnt    = cnt[v];
                best_found  = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        disp = '0;
        pop  = 1'b0;
        if (!fifo_empty) begin
            if (|hit) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (hit[v] && !pop) begin
                        disp[v] = 1'b1;
                        pop     = 1'b1;
                    end
                end
            end else if (|free_v) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (free_v[v] && !pop) begin
                        disp[v] = 1'b1;
                        pop     = 1'b1;
                    end
                end
            end
`ifdef HK628_VOICE_STEAL_EN
            else begin
                disp = steal_oh;
                pop  = 1'b1;
            end
`endif
        end
    end

    // Dispatch outranks expiry and the low-battery cut on the same voice.
    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            voice_en    <= '0;
            voice_tone  <= '0;
            voice_start <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                cnt[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                voice_start[v] <= disp[v];
                if (disp[v]) begin
                    voice_en[v]          <= 1'b1;
                    voice_tone[3*v +: 3] <= head;
                    cnt[v]               <= low_batt ? LOAD_LOW : LOAD_NORM;
                end else if (low_batt && v != 0) begin
                    voice_en[v] <= 1'b0;
                end else if (voice_en[v]) begin
                    if (cnt[v] == '0) begin
                        voice_en[v] <= 1'b0;
                    end else begin
                        cnt[v] <= cnt[v] - CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hk628_voice_scheduler.sv
// Scoreboard bench for hk628_voice_scheduler: expected voice_start events are
// queued as buttons are driven and matched against the pulses the DUT emits.
module tb_hk628_voice_scheduler;

    localparam int NV = 2;
    localparam int DB = 4;
    localparam int NC = 20;
    localparam int FD = 4;

    logic          CLK_50M = 1'b0;
    logic          RESET   = 1'b1;
    logic [7:0]    btn     = '0;
    logic          low_batt = 1'b0;
    logic [NV-1:0] voice_en;
    logic [3*NV-1:0] voice_tone;
    logic [NV-1:0] voice_start;
    logic [2:0]    fifo_level;
    logic          overrun;

    typedef struct {
        int voice;
        int tone;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    bit  sb_on  = 1'b1;

    hk628_voice_scheduler #(
        .NUM_VOICES  (NV),
        .DEBOUNCE_CYC(DB),
        .NOTE_CYC    (NC),
        .FIFO_DEPTH  (FD)
    ) dut (
        .CLK_50M    (CLK_50M),
        .RESET      (RESET),
        .btn        (btn),
        .low_batt   (low_batt),
        .voice_en   (voice_en),
        .voice_tone (voice_tone),
        .voice_start(voice_start),
        .fifo_level (fifo_level),
        .overrun    (overrun)
    );

    always #5 CLK_50M = ~CLK_50M;

    always @(posedge CLK_50M) cyc <= cyc + 1;

    // Scoreboard: every voice_start pulse must match the oldest expectation.
    always @(negedge CLK_50M) begin
        if (!RESET && sb_on) begin
            for (int v = 0; v < NV; v++) begin
                if (voice_start[v] === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL start_unexpected actual v%0d tone%0d cyc%0d required none",
                                 v, voice_tone[3*v +: 3], cyc);
                    end else begin
                        ev_t e;
                        e = exp_q.pop_front();
                        if (v !== e.voice || int'(voice_tone[3*v +: 3]) !== e.tone || cyc !== e.cyc) begin
                            errors++;
                            $display("FAIL start_event actual v%0d tone%0d cyc%0d required v%0d tone%0d cyc%0d",
                                     v, voice_tone[3*v +: 3], cyc, e.voice, e.tone, e.cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic push_ev(input int v, input int t, input int c);
        ev_t e;
        e.voice = v;
        e.tone  = t;
        e.cyc   = c;
        exp_q.push_back(e);
    endtask

    task automatic measure_en(input int v, input int rise_budget, output int len);
        int n;
        len = 0;
        n   = 0;
        while (voice_en[v] !== 1'b1 && n < rise_budget) begin
            @(negedge CLK_50M);
            n++;
        end
        if (voice_en[v] !== 1'b1) begin
            len = -1;
            return;
        end
        while (voice_en[v] === 1'b1 && len < 200) begin
            len++;
            @(negedge CLK_50M);
        end
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < 150 && !ok) begin
            @(negedge CLK_50M);
            ok = (voice_en === '0) && (fifo_level === '0);
            n++;
        end
        repeat (12) @(negedge CLK_50M);
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        repeat (3) @(negedge CLK_50M);
        RESET = 1'b0;
        @(negedge CLK_50M);
        checks++; if (voice_en !== '0) begin errors++; $display("FAIL rst_en actual %b required 0", voice_en); end
        checks++; if (voice_tone !== '0) begin errors++; $display("FAIL rst_tone actual %h required 0", voice_tone); end
        checks++; if (voice_start !== '0) begin errors++; $display("FAIL rst_start actual %b required 0", voice_start); end
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rst_level actual %0d required 0", fifo_level); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun actual %b required 0", overrun); end
    endtask

    task automatic test_single_press;
        int k, len;
        bit ok;
        @(negedge CLK_50M);
        k = cyc;
        btn[3] = 1'b1;
        push_ev(0, 3, k + DB + 5);
        measure_en(0, 30, len);
        checks++; if (len !== NC + 1) begin errors++; $display("FAIL single_en_len actual %0d required %0d", len, NC + 1); end
        checks++; if (voice_tone[2:0] !== 3'd3) begin errors++; $display("FAIL single_tone actual %0d required 3", voice_tone[2:0]); end
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL single_level actual %0d required 0", fifo_level); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL single_missing actual %0d required 0", exp_q.size()); end
        btn[3] = 1'b0;
        wait_idle(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_idle actual %b required 1", ok); end
    endtask

    task automatic test_bounce;
        int k, len;
        bit ok;
        @(negedge CLK_50M);
        for (int i = 0; i < 10; i++) begin
            btn[5] = (i % 2 == 0);
            repeat (2) @(negedge CLK_50M);
        end
        k = cyc;
        btn[5] = 1'b1;
        push_ev(0, 5, k + DB + 5);
        measure_en(0, 30, len);
        checks++; if (len !== NC + 1) begin errors++; $display("FAIL bounce_en_len actual %0d required %0d", len, NC + 1); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL bounce_missing actual %0d required 0", exp_q.size()); end
        btn[5] = 1'b0;
        wait_idle(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bounce_idle actual %b required 1", ok); end
    endtask

    task automatic test_retrigger;
        int k, fall;
        bit en1, ok;
        @(negedge CLK_50M);
        k = cyc;
        btn[2] = 1'b1;
        push_ev(0, 2, k + 9);
        repeat (9) @(negedge CLK_50M);
        btn[2] = 1'b0;
        repeat (10) @(negedge CLK_50M);
        btn[2] = 1'b1;
        push_ev(0, 2, k + 28);
        fall = -1;
        en1  = 1'b0;
        for (int n = 0; n < 60 && fall < 0; n++) begin
            @(negedge CLK_50M);
            if (voice_en[1] === 1'b1) en1 = 1'b1;
            if (voice_en[0] !== 1'b1) fall = cyc;
        end
        checks++; if (fall !== k + 49) begin errors++; $display("FAIL retrig_fall actual %0d required %0d", fall, k + 49); end
        checks++; if (en1 !== 1'b0) begin errors++; $display("FAIL retrig_v1_idle actual %b required 0", en1); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL retrig_missing actual %0d required 0", exp_q.size()); end
        btn[2] = 1'b0;
        wait_idle(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL retrig_idle actual %b required 1", ok); end
    endtask

    task automatic test_simultaneous;
        int k, n;
        bit ok;
        logic [2:0] lvl_req;
        @(negedge CLK_50M);
        k = cyc;
        btn[2:0] = 3'b111;
        push_ev(0, 0, k + 9);
        push_ev(1, 1, k + 10);
`ifdef HK628_VOICE_STEAL_EN
        push_ev(0, 2, k + 11);
        lvl_req = 3'd0;
`else
        push_ev(0, 2, k + 31);
        lvl_req = 3'd1;
`endif
        repeat (15) @(negedge CLK_50M);
        checks++; if (fifo_level !== lvl_req) begin errors++; $display("FAIL simul_level actual %0d required %0d", fifo_level, lvl_req); end
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge CLK_50M);
            n++;
        end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL simul_missing actual %0d required 0", exp_q.size()); end
        checks++; if (voice_tone[5:3] !== 3'd1) begin errors++; $display("FAIL simul_tone_v1 actual %0d required 1", voice_tone[5:3]); end
        btn[2:0] = 3'b000;
        wait_idle(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL simul_idle actual %b required 1", ok); end
    endtask

    task automatic test_low_batt;
        int k, k2, fall, len;
        bit en1, ok;
        @(negedge CLK_50M);
        k = cyc;
        btn[1:0] = 2'b11;
        push_ev(0, 0, k + 9);
        push_ev(1, 1, k + 10);
        repeat (14) @(negedge CLK_50M);
        btn[1:0] = 2'b00;
        low_batt = 1'b1;
        @(negedge CLK_50M);
        checks++; if (voice_en[1] !== 1'b0) begin errors++; $display("FAIL lowbatt_v1_cut actual %b required 0", voice_en[1]); end
        checks++; if (voice_en[0] !== 1'b1) begin errors++; $display("FAIL lowbatt_v0_keep actual %b required 1", voice_en[0]); end
        fall = -1;
        en1  = 1'b0;
        for (int n = 0; n < 40 && fall < 0; n++) begin
            @(negedge CLK_50M);
            if (voice_en[1] === 1'b1) en1 = 1'b1;
            if (voice_en[0] !== 1'b1) fall = cyc;
        end
        checks++; if (fall !== k + 30) begin errors++; $display("FAIL lowbatt_v0_fall actual %0d required %0d", fall, k + 30); end
        @(negedge CLK_50M);
        k2 = cyc;
        btn[4] = 1'b1;
        push_ev(0, 4, k2 + 9);
        measure_en(0, 30, len);
        checks++; if (len !== 2 * NC + 1) begin errors++; $display("FAIL lowbatt_len actual %0d required %0d", len, 2 * NC + 1); end
        if (voice_en[1] === 1'b1) en1 = 1'b1;
        checks++; if (en1 !== 1'b0) begin errors++; $display("FAIL lowbatt_v1_idle actual %b required 0", en1); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL lowbatt_missing actual %0d required 0", exp_q.size()); end
        btn[4] = 1'b0;
        low_batt = 1'b0;
        wait_idle(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL lowbatt_idle actual %b required 1", ok); end
    endtask

    task automatic test_overrun_reset;
        int k, ovr_cyc;
        @(negedge CLK_50M);
        k = cyc;
`ifdef HK628_VOICE_STEAL_EN
        sb_on = 1'b0;
`else
        push_ev(0, 0, k + 9);
        push_ev(1, 1, k + 10);
`endif
        btn = 8'hFF;
        repeat (8) @(negedge CLK_50M);
        btn[6] = 1'b0;
        repeat (7) @(negedge CLK_50M);
        btn[6] = 1'b1;
`ifndef HK628_VOICE_STEAL_EN
        repeat (5) @(negedge CLK_50M);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early actual %b required 0", overrun); end
        ovr_cyc = -1;
        for (int n = 0; n < 20 && ovr_cyc < 0; n++) begin
            if (overrun === 1'b1) ovr_cyc = cyc;
            else @(negedge CLK_50M);
        end
        checks++; if (ovr_cyc !== k + 22) begin errors++; $display("FAIL ovr_set_cyc actual %0d required %0d", ovr_cyc, k + 22); end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovr_level_full actual %0d required 4", fifo_level); end
`else
        repeat (10) @(negedge CLK_50M);
`endif
        RESET = 1'b1;
        btn   = '0;
        @(negedge CLK_50M);
        RESET = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst2_overrun actual %b required 0", overrun); end
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rst2_level actual %0d required 0", fifo_level); end
        checks++; if (voice_en !== '0) begin errors++; $display("FAIL rst2_en actual %b required 0", voice_en); end
        exp_q.delete();
        sb_on = 1'b1;
        repeat (20) @(negedge CLK_50M);
        checks++; if (voice_en !== '0) begin errors++; $display("FAIL rst2_quiet actual %b required 0", voice_en); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_retrigger();
        test_simultaneous();
        test_low_batt();
        test_overrun_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
